// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared widths, defaults and pipeline stage record for mac_accumulator
package mac_pkg;

  localparam int OPND_W    = 8;
  localparam int PROD_W    = 16;
  localparam int ACC_W_DEF = 24;
  localparam int CNT_W_DEF = 8;

  // S1 carries {a, b} in the payload, S2 carries the product; both are PROD_W wide.
  typedef struct packed {
    logic              valid;
    logic              last;
    logic [PROD_W-1:0] payload;
  } stage_t;

endpackage

// File: rtl/multiplier.sv
// rtl/multiplier.sv - combinational unsigned 8x8 array multiplier
module multiplier
  import mac_pkg::*;
(
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic [PROD_W-1:0] p
);

  always_comb begin
    p = '0;
    for (int i = 0; i < OPND_W; i++) begin
      if (b[i]) p = p + (PROD_W'(a) << i);
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - pipelined per-frame multiply-accumulate with valid/ready result port
// Optional MAC_SAT_EN: clamp the accumulator at all-ones on overflow instead of wrapping.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPND_W-1:0] in_a,
  input  logic [OPND_W-1:0] in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  stage_t            s1_q;
  stage_t            s2_q;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_q;
  logic              fresh_q;
  logic              stall;

  logic [ACC_W-1:0]  base_acc;
  logic [ACC_W-1:0]  sum;
  logic              carry;
  logic [ACC_W-1:0]  acc_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              ovf_nxt;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  multiplier u_multiplier (
    .a (s1_q.payload[PROD_W-1:OPND_W]),
    .b (s1_q.payload[OPND_W-1:0]),
    .p (prod)
  );

  // fresh_q marks that the next valid S2 term opens a new frame.
  always_comb begin
    base_acc     = fresh_q ? '0 : acc_q;
    {carry, sum} = {1'b0, base_acc} + (ACC_W + 1)'(s2_q.payload);
`ifdef MAC_SAT_EN
    acc_nxt      = carry ? {ACC_W{1'b1}} : sum;
`else
    acc_nxt      = sum;
`endif
    if (fresh_q)              cnt_nxt = CNT_W'(1);
    else if (cnt_q == CNT_MAX) cnt_nxt = cnt_q;
    else                      cnt_nxt = cnt_q + CNT_W'(1);
    ovf_nxt      = (fresh_q ? 1'b0 : ovf_q) | carry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      fresh_q   <= 1'b1;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_cnt   <= '0;
      out_ovf   <= 1'b0;
    end else if (!stall) begin
      s1_q <= '{valid: in_valid, last: in_last, payload: {in_a, in_b}};
      s2_q <= '{valid: s1_q.valid, last: s1_q.last, payload: prod};
      if (s2_q.valid) begin
        acc_q   <= acc_nxt;
        cnt_q   <= cnt_nxt;
        ovf_q   <= ovf_nxt;
        fresh_q <= s2_q.last;
      end
      // Not stalled implies any pending result is being taken this edge.
      if (s2_q.valid && s2_q.last) begin
        out_valid <= 1'b1;
        out_acc   <= acc_nxt;
        out_cnt   <= cnt_nxt;
        out_ovf   <= ovf_nxt;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - directed table-driven bench for mac_accumulator (ACC_W 24 and 16)
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_last;
  logic        out_ready;
  logic        in_ready;
  logic        out_valid;
  logic [23:0] out_acc;
  logic [7:0]  out_cnt;
  logic        out_ovf;
  logic        in_ready16;
  logic        out_valid16;
  logic [15:0] out_acc16;
  logic [7:0]  out_cnt16;
  logic        out_ovf16;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [23:0] acc;
    logic [7:0]  cnt;
    logic        ovf;
  } res_t;

  typedef struct {
    int              n;
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    longint          exp_acc;
    longint          exp_cnt;
    longint          exp_ovf;
  } frame_t;

  res_t   q[$];
  res_t   q16[$];
  frame_t tbl[5];

  always #5 clk = ~clk;

  mac_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_cnt   (out_cnt),
    .out_ovf   (out_ovf)
  );

  mac_accumulator #(.ACC_W(16), .CNT_W(8)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready16),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid16),
    .out_ready (out_ready),
    .out_acc   (out_acc16),
    .out_cnt   (out_cnt16),
    .out_ovf   (out_ovf16)
  );

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready)     q.push_back({out_acc, out_cnt, out_ovf});
    if (rst_n && out_valid16 && out_ready)   q16.push_back({8'd0, out_acc16, out_cnt16, out_ovf16});
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    bit ok;
    int g = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    do begin
      ok = in_ready;
      @(posedge clk);
      @(negedge clk);
      g++;
    end while (!ok && g < 100);
    if (!ok) check("send_accept_timeout", 0, 1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_res(input bit sel16, output res_t r);
    int n = 0;
    r = '0;
    while ((sel16 ? q16.size() : q.size()) == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if ((sel16 ? q16.size() : q.size()) == 0) check("result_timeout", 0, 1);
    else if (sel16) r = q16.pop_front();
    else            r = q.pop_front();
  endtask

  task automatic flush();
    idle();
    repeat (6) @(negedge clk);
    q.delete();
    q16.delete();
  endtask

  initial begin
    res_t r;

    tbl[0] = '{3, {8'd0, 8'd7, 8'd5, 8'd3},     {8'd0, 8'd8, 8'd6, 8'd4},   98,    3, 0};
    tbl[1] = '{1, {8'd0, 8'd0, 8'd0, 8'd255},   {8'd0, 8'd0, 8'd0, 8'd255}, 65025, 1, 0};
    tbl[2] = '{2, {8'd0, 8'd0, 8'd17, 8'd0},    {8'd0, 8'd0, 8'd0, 8'd200}, 0,     2, 0};
    tbl[3] = '{4, {8'd2, 8'd255, 8'd1, 8'd10},  {8'd128, 8'd1, 8'd1, 8'd20}, 712,  4, 0};
    tbl[4] = '{1, {8'd0, 8'd0, 8'd0, 8'd100},   {8'd0, 8'd0, 8'd0, 8'd100}, 10000, 1, 0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_acc",   out_acc, 0);
    check("reset_out_cnt",   out_cnt, 0);
    check("reset_out_ovf",   out_ovf, 0);
    check("reset_in_ready",  in_ready, 1);
    check("reset_in_ready16", in_ready16, 1);

    // Exact latency: last pair at edge N, result visible only after edge N+2.
    send(8'd3, 8'd4, 1'b0);
    send(8'd5, 8'd6, 1'b0);
    send(8'd7, 8'd8, 1'b1);
    idle();
    check("lat_n0_valid", out_valid, 0);
    @(negedge clk);
    check("lat_n1_valid", out_valid, 0);
    @(negedge clk);
    check("lat_n2_valid", out_valid, 1);
    check("lat_acc", out_acc, 98);
    check("lat_cnt", out_cnt, 3);
    check("lat_ovf", out_ovf, 0);
    @(negedge clk);
    check("lat_n3_valid", out_valid, 0);
    flush();

    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < tbl[i].n; j++) send(tbl[i].a[j], tbl[i].b[j], j == tbl[i].n - 1);
      idle();
      wait_res(1'b0, r);
      check($sformatf("tbl%0d_acc", i), r.acc, tbl[i].exp_acc);
      check($sformatf("tbl%0d_cnt", i), r.cnt, tbl[i].exp_cnt);
      check($sformatf("tbl%0d_ovf", i), r.ovf, tbl[i].exp_ovf);
    end
    flush();

    // Back-to-back single-term frames complete on consecutive cycles.
    send(8'd1, 8'd1, 1'b1);
    send(8'd2, 8'd2, 1'b1);
    idle();
    @(negedge clk);
    check("b2b_first_valid", out_valid, 1);
    check("b2b_first_acc", out_acc, 1);
    @(negedge clk);
    check("b2b_second_valid", out_valid, 1);
    check("b2b_second_acc", out_acc, 4);
    check("b2b_second_cnt", out_cnt, 1);
    flush();

    // 16-bit accumulator overflow; the 24-bit instance must not overflow.
    send(8'd255, 8'd255, 1'b0);
    send(8'd255, 8'd255, 1'b1);
    idle();
    wait_res(1'b1, r);
`ifdef MAC_SAT_EN
    check("ovf16_acc", r.acc, 65535);
`else
    check("ovf16_acc", r.acc, 64514);
`endif
    check("ovf16_ovf", r.ovf, 1);
    check("ovf16_cnt", r.cnt, 2);
    wait_res(1'b0, r);
    check("ovf24_acc", r.acc, 130050);
    check("ovf24_ovf", r.ovf, 0);
    flush();

    // Term counter saturates at 255.
    for (int k = 0; k < 300; k++) send(8'd1, 8'd1, k == 299);
    idle();
    wait_res(1'b0, r);
    check("sat_cnt_acc", r.acc, 300);
    check("sat_cnt_cnt", r.cnt, 255);
    check("sat_cnt_ovf", r.ovf, 0);
    flush();

    // Backpressure: result held, input blocked, then both results drain in order.
    out_ready = 1'b0;
    send(8'd2, 8'd3, 1'b1);
    send(8'd4, 8'd4, 1'b1);
    idle();
    repeat (4) @(negedge clk);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_out_acc_held", out_acc, 6);
    check("bp_none_taken", q.size(), 0);
    out_ready = 1'b1;
    wait_res(1'b0, r);
    check("bp_first_acc", r.acc, 6);
    wait_res(1'b0, r);
    check("bp_second_acc", r.acc, 16);
    repeat (4) @(negedge clk);
    check("bp_no_duplicate", q.size(), 0);
    check("bp_in_ready_after", in_ready, 1);
    flush();

    // Reset mid-frame discards the partial sum.
    send(8'd9, 8'd9, 1'b0);
    send(8'd9, 8'd9, 1'b0);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_out_valid", out_valid, 0);
    q.delete();
    send(8'd2, 8'd2, 1'b1);
    idle();
    wait_res(1'b0, r);
    check("rst_mid_acc", r.acc, 4);
    check("rst_mid_cnt", r.cnt, 1);
    check("rst_mid_ovf", r.ovf, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
